vga_timing_gen: RTL and testbench

Runtime-programmable VGA timing generator, successor to the fixed 640x480 generator. Mode geometry and sync polarities come from configuration inputs and are switched glitch-free at frame boundaries, with a legality check on every request. Also provides a frame counter and an optional lookahead fetch coordinate stream for pixel pipelines. Sits between the pixel clock domain's reset/config logic and the video output and renderer.

---
 rtl/vga_timing_gen.sv | 216 +++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Runtime-programmable VGA timing generator: counters, registered decodes, staged
// frame-boundary mode switching and a frame counter. Define VGA_TIMING_PREFETCH_EN for lookahead fetch coordinates.
module vga_timing_gen #(
  parameter int XW       = 11,
  parameter int YW       = 10,
  parameter int FRAME_W  = 8,
  parameter int PREFETCH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [XW-1:0]      cfg_h_active,
  input  logic [XW-1:0]      cfg_h_sync_start,
  input  logic [XW-1:0]      cfg_h_sync_end,
  input  logic [XW-1:0]      cfg_h_total,
  input  logic [YW-1:0]      cfg_v_active,
  input  logic [YW-1:0]      cfg_v_sync_start,
  input  logic [YW-1:0]      cfg_v_sync_end,
  input  logic [YW-1:0]      cfg_v_total,
  input  logic               cfg_hs_pol,
  input  logic               cfg_vs_pol,
  input  logic               cfg_load,
  output logic               cfg_pending,
  output logic               cfg_error,
  output logic [XW-1:0]      vga_x,
  output logic [YW-1:0]      vga_y,
  output logic               vga_visible,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_horizontal_blank_strobe,
  output logic               vga_vertical_blank_strobe,
  output logic [FRAME_W-1:0] frame_count,
  output logic [XW-1:0]      fetch_x,
  output logic [YW-1:0]      fetch_y,
  output logic               fetch_visible
);

  typedef struct packed {
    logic [XW-1:0] h_active;
    logic [XW-1:0] h_sync_start;
    logic [XW-1:0] h_sync_end;
    logic [XW-1:0] h_total;
    logic [YW-1:0] v_active;
    logic [YW-1:0] v_sync_start;
    logic [YW-1:0] v_sync_end;
    logic [YW-1:0] v_total;
    logic          hs_pol;
    logic          vs_pol;
  } cfg_t;

  // One pixel position together with every decode that refers to it.
  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          vis;
    logic          hs;
    logic          vs;
    logic          hstb;
    logic          vstb;
  } pix_t;

`ifdef VGA_TIMING_PREFETCH_EN
  localparam int RESET_LEAD = PREFETCH;
`else
  localparam int RESET_LEAD = 0;
`endif

  function automatic logic cfg_legal(input cfg_t c);
    logic h_ok;
    logic v_ok;
    h_ok = (c.h_active >= XW'(1)) && (c.h_active <= c.h_sync_start) &&
           (c.h_sync_start < c.h_sync_end) && (c.h_sync_end <= c.h_total) &&
           (c.h_total >= XW'(2));
    v_ok = (c.v_active >= YW'(1)) && (c.v_active <= c.v_sync_start) &&
           (c.v_sync_start < c.v_sync_end) && (c.v_sync_end <= c.v_total) &&
           (c.v_total >= YW'(2));
    return h_ok && v_ok;
  endfunction

  function automatic void advance(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                  input cfg_t c, output logic [XW-1:0] nx,
                                  output logic [YW-1:0] ny, output logic wrap);
    logic h_last;
    logic v_last;
    h_last = (x == c.h_total - XW'(1));
    v_last = (y == c.v_total - YW'(1));
    wrap   = h_last && v_last;
    nx     = h_last ? '0 : x + XW'(1);
    ny     = h_last ? (v_last ? '0 : y + YW'(1)) : y;
  endfunction

  function automatic pix_t decode(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                  input cfg_t c);
    pix_t p;
    p.x    = x;
    p.y    = y;
    p.vis  = (x < c.h_active) && (y < c.v_active);
    p.hs   = ((x >= c.h_sync_start) && (x < c.h_sync_end)) ? c.hs_pol : ~c.hs_pol;
    p.vs   = ((y >= c.v_sync_start) && (y < c.v_sync_end)) ? c.vs_pol : ~c.vs_pol;
    p.hstb = (x == c.h_active);
    p.vstb = p.hstb && (y == c.v_active - YW'(1));
    return p;
  endfunction

  // Position reached after k clocks from (0,0) under config c, with its decodes.
  function automatic pix_t pix_at(input int k, input cfg_t c);
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          unused_wrap;
    x = '0;
    y = '0;
    for (int i = 0; i < PREFETCH; i++) begin
      if (i < k) advance(x, y, c, x, y, unused_wrap);
    end
    return decode(x, y, c);
  endfunction

  cfg_t                cfg_in;
  cfg_t                act_q, act_d;
  cfg_t                pend_cfg_q, pend_cfg_d;
  logic                pend_q, pend_d;
  logic                err_q, err_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  pix_t                mst_q, mst_d;
  pix_t                vga_pix;
  logic [XW-1:0]       nx;
  logic [YW-1:0]       ny;
  logic                wrap;
  logic                load_ok;

  assign cfg_in = '{h_active: cfg_h_active, h_sync_start: cfg_h_sync_start,
                    h_sync_end: cfg_h_sync_end, h_total: cfg_h_total,
                    v_active: cfg_v_active, v_sync_start: cfg_v_sync_start,
                    v_sync_end: cfg_v_sync_end, v_total: cfg_v_total,
                    hs_pol: cfg_hs_pol, vs_pol: cfg_vs_pol};

  assign load_ok = cfg_load && cfg_legal(cfg_in);

  always_comb begin
    nx         = '0;
    ny         = '0;
    wrap       = 1'b0;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_cfg_d = pend_cfg_q;
    frame_d    = frame_q;
    err_d      = cfg_load && !load_ok;
    advance(mst_q.x, mst_q.y, act_q, nx, ny, wrap);
    // Apply uses the old pending value so a load on the wrap cycle is staged for the next frame.
    if (wrap) begin
      frame_d = frame_q + FRAME_W'(1);
      if (pend_q) begin
        act_d  = pend_cfg_q;
        pend_d = 1'b0;
      end
    end
    if (load_ok) begin
      pend_cfg_d = cfg_in;
      pend_d     = 1'b1;
    end
    mst_d = decode(nx, ny, act_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      act_q      <= cfg_in;
      pend_cfg_q <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
      frame_q    <= '0;
      mst_q      <= pix_at(RESET_LEAD, cfg_in);
    end else begin
      act_q      <= act_d;
      pend_cfg_q <= pend_cfg_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      frame_q    <= frame_d;
      mst_q      <= mst_d;
    end
  end

`ifdef VGA_TIMING_PREFETCH_EN
  // pipe_q[PREFETCH-1] is the oldest stage; reset preloads positions 0..PREFETCH-1.
  pix_t pipe_q [PREFETCH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < PREFETCH; k++) pipe_q[k] <= pix_at(PREFETCH - 1 - k, cfg_in);
    end else begin
      pipe_q[0] <= mst_q;
      for (int k = 1; k < PREFETCH; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  assign vga_pix       = pipe_q[PREFETCH-1];
  assign fetch_x       = mst_q.x;
  assign fetch_y       = mst_q.y;
  assign fetch_visible = mst_q.vis;
`else
  assign vga_pix       = mst_q;
  assign fetch_x       = '0;
  assign fetch_y       = '0;
  assign fetch_visible = 1'b0;
`endif

  assign vga_x                       = vga_pix.x;
  assign vga_y                       = vga_pix.y;
  assign vga_visible                 = vga_pix.vis;
  assign vga_hs                      = vga_pix.hs;
  assign vga_vs                      = vga_pix.vs;
  assign vga_horizontal_blank_strobe = vga_pix.hstb;
  assign vga_vertical_blank_strobe   = vga_pix.vstb;
  assign cfg_pending                 = pend_q;
  assign cfg_error                   = err_q;
  assign frame_count                 = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen: tiny modes, strobes, legal/illegal
// loads, load on the wrap cycle, mid-frame reset and (when enabled) fetch lookahead.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PREFETCH_EN
  localparam int LAG = 4;
`else
  localparam int LAG = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] cfg_h_active, cfg_h_sync_start, cfg_h_sync_end, cfg_h_total;
  logic [9:0]  cfg_v_active, cfg_v_sync_start, cfg_v_sync_end, cfg_v_total;
  logic        cfg_hs_pol, cfg_vs_pol, cfg_load;
  logic        cfg_pending, cfg_error;
  logic [10:0] vga_x, fetch_x;
  logic [9:0]  vga_y, fetch_y;
  logic        vga_visible, vga_hs, vga_vs, hstb, vstb, fetch_visible;
  logic [7:0]  frame_count;

  int checks = 0;
  int errors = 0;

  vga_timing_gen #(.XW(11), .YW(10), .FRAME_W(8), .PREFETCH(4)) dut (
    .clock(clock), .reset(reset),
    .cfg_h_active(cfg_h_active), .cfg_h_sync_start(cfg_h_sync_start),
    .cfg_h_sync_end(cfg_h_sync_end), .cfg_h_total(cfg_h_total),
    .cfg_v_active(cfg_v_active), .cfg_v_sync_start(cfg_v_sync_start),
    .cfg_v_sync_end(cfg_v_sync_end), .cfg_v_total(cfg_v_total),
    .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol), .cfg_load(cfg_load),
    .cfg_pending(cfg_pending), .cfg_error(cfg_error),
    .vga_x(vga_x), .vga_y(vga_y), .vga_visible(vga_visible),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_horizontal_blank_strobe(hstb), .vga_vertical_blank_strobe(vstb),
    .frame_count(frame_count),
    .fetch_x(fetch_x), .fetch_y(fetch_y), .fetch_visible(fetch_visible)
  );

  always #5 clock = ~clock;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_mode(input int ha, hss, hse, ht, va, vss, vse, vt, input logic hp, vp);
    cfg_h_active = 11'(ha); cfg_h_sync_start = 11'(hss);
    cfg_h_sync_end = 11'(hse); cfg_h_total = 11'(ht);
    cfg_v_active = 10'(va); cfg_v_sync_start = 10'(vss);
    cfg_v_sync_end = 10'(vse); cfg_v_total = 10'(vt);
    cfg_hs_pol = hp; cfg_vs_pol = vp;
  endtask

  task automatic test_reset;
    set_mode(8, 10, 12, 16, 4, 5, 6, 8, 1'b0, 1'b0);
    cfg_load = 1'b0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    checks++; if (vga_x !== 11'd0 || vga_y !== 10'd0) begin errors++;
      $display("FAIL reset_pos got x=%0d y=%0d exp 0 0", vga_x, vga_y); end
    checks++; if (vga_visible !== 1'b1 || vga_hs !== 1'b1 || vga_vs !== 1'b1) begin errors++;
      $display("FAIL reset_decode got vis=%b hs=%b vs=%b exp 1 1 1", vga_visible, vga_hs, vga_vs); end
    checks++; if (hstb !== 1'b0 || vstb !== 1'b0) begin errors++;
      $display("FAIL reset_strobes got h=%b v=%b exp 0 0", hstb, vstb); end
    checks++; if (frame_count !== 8'd0 || cfg_pending !== 1'b0 || cfg_error !== 1'b0) begin errors++;
      $display("FAIL reset_status got frame=%0d pend=%b err=%b exp 0 0 0", frame_count, cfg_pending, cfg_error); end
    checks++; if (fetch_x !== 11'(LAG) || fetch_y !== 10'd0) begin errors++;
      $display("FAIL reset_fetch got fx=%0d fy=%0d exp %0d 0", fetch_x, fetch_y, LAG); end
  endtask

  // Mode A over two frames: position, sync, visible, strobes and frame counter every clock.
  task automatic test_frame;
    int vis_cnt [2];
    int hs_cnt [2];
    int vs_cnt [2];
    int ex, ey, ef;
    logic e_hs, e_vs, e_vis, e_hstb, e_vstb;
    vis_cnt = '{0, 0}; hs_cnt = '{0, 0}; vs_cnt = '{0, 0};
    for (int c = 0; c < 256; c++) begin
      ex = c % 16; ey = (c / 16) % 8; ef = c / 128;
      e_hs = !(ex >= 10 && ex < 12);
      e_vs = !(ey == 5);
      e_vis = (ex < 8) && (ey < 4);
      e_hstb = (ex == 8);
      e_vstb = (ex == 8) && (ey == 3);
      checks++; if (vga_x !== 11'(ex) || vga_y !== 10'(ey)) begin errors++;
        $display("FAIL frame_pos c=%0d got %0d,%0d exp %0d,%0d", c, vga_x, vga_y, ex, ey); end
      checks++; if (vga_hs !== e_hs || vga_vs !== e_vs) begin errors++;
        $display("FAIL frame_sync c=%0d got hs=%b vs=%b exp %b %b", c, vga_hs, vga_vs, e_hs, e_vs); end
      checks++; if (vga_visible !== e_vis) begin errors++;
        $display("FAIL frame_vis c=%0d got %b exp %b", c, vga_visible, e_vis); end
      checks++; if (hstb !== e_hstb || vstb !== e_vstb) begin errors++;
        $display("FAIL frame_strobe c=%0d got h=%b v=%b exp %b %b", c, hstb, vstb, e_hstb, e_vstb); end
      checks++; if (frame_count !== 8'(ef)) begin errors++;
        $display("FAIL frame_count c=%0d got %0d exp %0d", c, frame_count, ef); end
      if (vga_visible === 1'b1) vis_cnt[ef]++;
      if (hstb === 1'b1) hs_cnt[ef]++;
      if (vstb === 1'b1) vs_cnt[ef]++;
      step();
    end
    for (int f = 0; f < 2; f++) begin
      checks++; if (vis_cnt[f] != 32 || hs_cnt[f] != 8 || vs_cnt[f] != 1) begin errors++;
        $display("FAIL frame_totals f=%0d got vis=%0d hstb=%0d vstb=%0d exp 32 8 1", f, vis_cnt[f], hs_cnt[f], vs_cnt[f]); end
    end
    checks++; if (frame_count !== 8'd2 || vga_x !== 11'd0 || vga_y !== 10'd0) begin errors++;
      $display("FAIL frame_end got frame=%0d x=%0d y=%0d exp 2 0 0", frame_count, vga_x, vga_y); end
  endtask

  task automatic test_illegal_load;
    int n;
    set_mode(8, 7, 12, 16, 4, 5, 6, 8, 1'b0, 1'b0);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    checks++; if (cfg_error !== 1'b1 || cfg_pending !== 1'b0) begin errors++;
      $display("FAIL illegal_flag got err=%b pend=%b exp 1 0", cfg_error, cfg_pending); end
    step();
    checks++; if (cfg_error !== 1'b0 || cfg_pending !== 1'b0 || vga_x !== 11'd2) begin errors++;
      $display("FAIL illegal_pulse got err=%b pend=%b x=%0d exp 0 0 2", cfg_error, cfg_pending, vga_x); end
    n = 0;
    while (!(vga_x === 11'd0 && vga_y === 10'd0) && n < 300) begin
      step();
      n++;
    end
    checks++; if (n != 126 || frame_count !== 8'd3) begin errors++;
      $display("FAIL illegal_timing got steps=%0d frame=%0d exp 126 3", n, frame_count); end
  endtask

  task automatic test_legal_load;
    logic e_hs, e_vs, e_vis;
    step(20);
    set_mode(6, 7, 8, 10, 3, 4, 5, 6, 1'b1, 1'b1);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    checks++; if (cfg_pending !== 1'b1 || cfg_error !== 1'b0) begin errors++;
      $display("FAIL legal_pend got pend=%b err=%b exp 1 0", cfg_pending, cfg_error); end
    step(106);
    checks++; if (vga_x !== 11'd15 || vga_y !== 10'd7 || cfg_pending !== 1'b1 || frame_count !== 8'd3) begin errors++;
      $display("FAIL legal_prewrap got x=%0d y=%0d pend=%b frame=%0d exp 15 7 1 3", vga_x, vga_y, cfg_pending, frame_count); end
    step();
    checks++; if (cfg_pending !== 1'b0 || frame_count !== 8'd4) begin errors++;
      $display("FAIL legal_apply got pend=%b frame=%0d exp 0 4", cfg_pending, frame_count); end
    for (int c = 0; c < 60; c++) begin
      e_hs = ((c % 10) == 7);
      e_vs = ((c / 10) == 4);
      e_vis = ((c % 10) < 6) && ((c / 10) < 3);
      checks++; if (vga_x !== 11'(c % 10) || vga_y !== 10'(c / 10)) begin errors++;
        $display("FAIL modeb_pos c=%0d got %0d,%0d exp %0d,%0d", c, vga_x, vga_y, c % 10, c / 10); end
      checks++; if (vga_hs !== e_hs || vga_vs !== e_vs || vga_visible !== e_vis) begin errors++;
        $display("FAIL modeb_decode c=%0d got hs=%b vs=%b vis=%b exp %b %b %b", c, vga_hs, vga_vs, vga_visible, e_hs, e_vs, e_vis); end
      step();
    end
    checks++; if (vga_x !== 11'd0 || vga_y !== 10'd0 || frame_count !== 8'd5) begin errors++;
      $display("FAIL modeb_end got x=%0d y=%0d frame=%0d exp 0 0 5", vga_x, vga_y, frame_count); end
  endtask

  task automatic test_back_to_back;
    set_mode(8, 10, 12, 16, 4, 5, 6, 8, 1'b0, 1'b0);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    step(58);
    checks++; if (vga_x !== 11'd9 || vga_y !== 10'd5 || cfg_pending !== 1'b1) begin errors++;
      $display("FAIL b2b_prewrap got x=%0d y=%0d pend=%b exp 9 5 1", vga_x, vga_y, cfg_pending); end
    set_mode(8, 9, 10, 12, 2, 3, 4, 5, 1'b0, 1'b0);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    checks++; if (vga_x !== 11'd0 || vga_y !== 10'd0 || cfg_pending !== 1'b1 || frame_count !== 8'd6) begin errors++;
      $display("FAIL b2b_wrap got x=%0d y=%0d pend=%b frame=%0d exp 0 0 1 6", vga_x, vga_y, cfg_pending, frame_count); end
    step(15);
    checks++; if (vga_x !== 11'd15 || vga_y !== 10'd0) begin errors++;
      $display("FAIL b2b_first_mode got x=%0d y=%0d exp 15 0", vga_x, vga_y); end
    step(112);
    checks++; if (vga_x !== 11'd15 || vga_y !== 10'd7 || cfg_pending !== 1'b1) begin errors++;
      $display("FAIL b2b_hold got x=%0d y=%0d pend=%b exp 15 7 1", vga_x, vga_y, cfg_pending); end
    step();
    checks++; if (cfg_pending !== 1'b0 || frame_count !== 8'd7) begin errors++;
      $display("FAIL b2b_second_apply got pend=%b frame=%0d exp 0 7", cfg_pending, frame_count); end
    step(9);
    checks++; if (vga_x !== 11'd9 || vga_hs !== 1'b0) begin errors++;
      $display("FAIL b2b_modec_sync got x=%0d hs=%b exp 9 0", vga_x, vga_hs); end
    step(3);
    checks++; if (vga_x !== 11'd0 || vga_y !== 10'd1) begin errors++;
      $display("FAIL b2b_modec_line got x=%0d y=%0d exp 0 1", vga_x, vga_y); end
    step(48);
    checks++; if (vga_x !== 11'd0 || vga_y !== 10'd0 || frame_count !== 8'd8) begin errors++;
      $display("FAIL b2b_modec_frame got x=%0d y=%0d frame=%0d exp 0 0 8", vga_x, vga_y, frame_count); end
  endtask

  task automatic test_reset_mid;
    step(30);
    set_mode(6, 7, 8, 10, 3, 4, 5, 6, 1'b1, 1'b1);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    checks++; if (cfg_pending !== 1'b1) begin errors++;
      $display("FAIL rstmid_pend got %b exp 1", cfg_pending); end
    set_mode(8, 10, 12, 16, 4, 5, 6, 8, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (vga_x !== 11'd0 || vga_y !== 10'd0 || cfg_pending !== 1'b0 || frame_count !== 8'd0) begin errors++;
      $display("FAIL rstmid_state got x=%0d y=%0d pend=%b frame=%0d exp 0 0 0 0", vga_x, vga_y, cfg_pending, frame_count); end
    checks++; if (fetch_x !== 11'(LAG)) begin errors++;
      $display("FAIL rstmid_fetch got %0d exp %0d", fetch_x, LAG); end
    step(127);
    checks++; if (vga_x !== 11'd15 || vga_y !== 10'd7) begin errors++;
      $display("FAIL rstmid_discard got x=%0d y=%0d exp 15 7", vga_x, vga_y); end
    step();
    checks++; if (vga_x !== 11'd0 || vga_y !== 10'd0 || frame_count !== 8'd1) begin errors++;
      $display("FAIL rstmid_frame got x=%0d y=%0d frame=%0d exp 0 0 1", vga_x, vga_y, frame_count); end
  endtask

`ifdef VGA_TIMING_PREFETCH_EN
  task automatic test_prefetch;
    logic [10:0] fx_h [300];
    logic [9:0]  fy_h [300];
    logic [10:0] vx_h [300];
    logic [9:0]  vy_h [300];
    logic        fv_h [300];
    logic        vv_h [300];
    for (int t = 0; t < 300; t++) begin
      fx_h[t] = fetch_x; fy_h[t] = fetch_y; fv_h[t] = fetch_visible;
      vx_h[t] = vga_x; vy_h[t] = vga_y; vv_h[t] = vga_visible;
      if (t == 100) begin
        set_mode(6, 7, 8, 10, 3, 4, 5, 6, 1'b1, 1'b1);
        cfg_load = 1'b1;
      end else begin
        cfg_load = 1'b0;
      end
      step();
    end
    for (int t = 0; t < 296; t++) begin
      checks++; if (vx_h[t+4] !== fx_h[t] || vy_h[t+4] !== fy_h[t] || vv_h[t+4] !== fv_h[t]) begin errors++;
        $display("FAIL prefetch_lead t=%0d got vga=%0d,%0d,%b exp %0d,%0d,%b", t, vx_h[t+4], vy_h[t+4], vv_h[t+4], fx_h[t], fy_h[t], fv_h[t]); end
    end
    set_mode(8, 10, 12, 16, 4, 5, 6, 8, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    cfg_load = 1'b0;
    test_reset();
`ifdef VGA_TIMING_PREFETCH_EN
    test_prefetch();
    test_reset_mid();
`else
    test_frame();
    test_illegal_load();
    test_legal_load();
    test_back_to_back();
    test_reset_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
